cfg0_req_engine: RTL and testbench
==================================

# cfg0_req_engine

Completer-facing Type-0 configuration request engine on the RC side of the scan subsystem. It accepts the `cfg0w_en`/`cfg0r_en`/`op_start` request handshake from the configuration initiator. It serialises each request as a one-DW CfgWr0/CfgRd0 TLP onto a 32-bit TX stream, then waits for the matching Cpl/CplD on the RX stream. It returns read data, completion status and `op_over` to the initiator.

## Interface
Parameters:
- `REQ_ID`, 16'h0000: requester ID (RC BDF) placed in DW1 and matched in completions.
- `TARGET_BDF`, 16'h0100: target bus/dev/func placed in DW2.
- `TIMEOUT_CYC`, 50000: completion timeout in clock cycles (≥ 2).

Ports (clock, reset first):
- `rc_core_clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg0w_en`  in  1  write request select.
- `cfg0r_en`  in  1  read request select.
- `op_start`  in  1  one-cycle request strobe.
- `cfg0w_addr`  in  32  write register byte address; bits [11:2] used.
- `cfg0w_data`  in  32  write payload.
- `cfg0r_addr`  in  32  read register byte address; bits [11:2] used.
- `cfg0w_op_over`  out  1  write done, level.
- `cfg0r_op_over`  out  1  read done, level.
- `cfg0r_data`  out  32  read result, held.
- `cfg0r_data_vld`  out  1  one-cycle pulse when `cfg0r_data` updates.
- `cpl_status`  out  3  status of last completion (000 SC, 001 UR, 010 CRS, 100 CA).
- `timeout_err`  out  1  last request timed out, held until next `op_start`.
- `busy`  out  1  state ≠ IDLE.
- `tx_data`  out  32  TLP DW.
- `tx_valid`, `tx_sop`, `tx_eop`  out  1 each.
- `tx_ready`  in  1  sink accepts the beat when `tx_valid & tx_ready`.
- `rx_data`  in  32  completion DW.
- `rx_valid`, `rx_sop`, `rx_eop`  in  1 each; the engine is always ready on RX.

## Operation
- States: IDLE, TX_H0, TX_H1, TX_H2, TX_D, WAIT_CPL, DONE.
- IDLE: on `op_start`, latch the op, address, data and current tag, then go to TX_H0.
  - If both enables are high, the write wins.
  - If neither enable is high, `op_start` is ignored.
  - `op_start` in any state other than IDLE is ignored.
- TX DWs:
  - H0 = {fmt_type, 8'h00, 6'b0, 10'd1}. fmt_type is 8'h44 for a write and 8'h04 for a read.
  - H1 = {REQ_ID, tag, 4'h0, 4'hF}.
  - H2 = {TARGET_BDF, 4'h0, addr[11:2], 2'b00}.
  - D = cfg0w_data, sent for writes only. No byte swapping.
  - `tx_sop` is set on H0. `tx_eop` is set on H2 for a read and on D for a write.
- Tag: 8-bit, increments on entry to TX_H0 (value used is the pre-increment value), wraps 8'hFF→8'h00.
- WAIT_CPL:
  - Index RX beats from `rx_sop` (index 0).
  - A completion matches when:
    - DW0[31:24] is 8'h4A (CplD) or 8'h0A (Cpl), and
    - DW2[31:16] = REQ_ID, and
    - DW2[15:8] = latched tag.
  - Non-matching packets are dropped silently.
  - On `rx_eop` of a matching packet:
    - `cpl_status` ← DW1[15:13].
    - For a read: `cfg0r_data` ← DW3 if status = SC and the packet is a CplD; otherwise 32'hFFFF_FFFF. Pulse `cfg0r_data_vld`.
    - Go to DONE.
- Timeout: counter clears on WAIT_CPL entry. When it reaches TIMEOUT_CYC-1, go to DONE and set `timeout_err`=1. A read also gets `cfg0r_data`=32'hFFFF_FFFF with a `cfg0r_data_vld` pulse. `cpl_status` is unchanged.
- DONE: assert `cfg0w_op_over` or `cfg0r_op_over` (per latched op). Hold it until the corresponding enable is low, then return to IDLE on the next cycle.
- RX traffic outside WAIT_CPL is discarded, including late completions after a timeout.

## Timing
- Reset values:
  - state IDLE, tag 8'h00.
  - All `tx_*` = 0.
  - Both `op_over` = 0, `cfg0r_data` = 0, `cfg0r_data_vld` = 0.
  - `cpl_status` = 0, `timeout_err` = 0, `busy` = 0.
- `tx_valid` and H0 appear the cycle after `op_start`.
- Each beat holds `tx_data`/`tx_sop`/`tx_eop` stable while `tx_ready` = 0. The next beat follows in the cycle after acceptance, with no bubbles.
- WAIT_CPL is entered the cycle after the last TX beat is accepted.
- `op_over` and `cfg0r_data_vld` assert the cycle after the matching `rx_eop` beat, or the cycle after timeout.
- Minimum latency with `tx_ready` = 1 and a zero-gap completion:
  - Read: `op_start` → `cfg0r_op_over` = 3 + 4 + 1 = 8 cycles.
  - Write: 4 + 3 + 1 = 8 cycles (the Cpl is 3 DWs).
- `rst` asserted mid-operation: all outputs return to reset values the next cycle and any in-flight completion is ignored.

## Test plan
- Read, `cfg0r_addr` = 32'h0000_0000, completer returns CplD tag 0, SC, DW3 = 32'h1234_10EE → TX DWs 04000001 / 0000000F / 01000000. Then `cfg0r_data` = 32'h1234_10EE, one `vld` pulse, `cfg0r_op_over` high until `cfg0r_en` drops.
- Write, addr 32'h0000_0004, data 32'h0011_0007, with `tx_ready` toggling 1/0 → 4 beats, each stable while stalled, H0 = 44000001, D = 00110007. Cpl SC → `cfg0w_op_over`, `cpl_status` = 000.
- Read answered by a Cpl with status UR, preceded by a CplD with the wrong tag → wrong packet ignored, `cfg0r_data` = FFFFFFFF, `cpl_status` = 001.
- No completion, TIMEOUT_CYC = 100 → `timeout_err` = 1 exactly 100 cycles after WAIT_CPL entry, data FFFFFFFF. A late completion is ignored. The next `op_start` clears `timeout_err`.
- 257 back-to-back reads → tags 00..FF then 00, all complete correctly.
- `rst` pulsed during WAIT_CPL → immediate IDLE, `busy` = 0, tag = 0, a subsequent stale completion produces no `op_over`.

Source files
------------

// File: rtl/cfg0_req_engine.sv
// Type-0 configuration request engine: serialises CfgWr0/CfgRd0 TLPs onto a
// 32-bit TX stream and matches the returning Cpl/CplD on the RX stream.
module cfg0_req_engine #(
    parameter logic [15:0] REQ_ID      = 16'h0000,
    parameter logic [15:0] TARGET_BDF  = 16'h0100,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        rc_core_clk,
    input  logic        rst,
    input  logic        cfg0w_en,
    input  logic        cfg0r_en,
    input  logic        op_start,
    input  logic [31:0] cfg0w_addr,
    input  logic [31:0] cfg0w_data,
    input  logic [31:0] cfg0r_addr,
    output logic        cfg0w_op_over,
    output logic        cfg0r_op_over,
    output logic [31:0] cfg0r_data,
    output logic        cfg0r_data_vld,
    output logic [2:0]  cpl_status,
    output logic        timeout_err,
    output logic        busy,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    output logic        tx_sop,
    output logic        tx_eop,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    input  logic        rx_sop,
    input  logic        rx_eop
);

    localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYC);
    localparam int unsigned IDX_W    = 3;
    localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  FT_WR    = 8'h44;
    localparam logic [7:0]  FT_RD    = 8'h04;
    localparam logic [7:0]  FT_CPLD  = 8'h4A;
    localparam logic [7:0]  FT_CPL   = 8'h0A;
    localparam logic [2:0]  CPL_SC   = 3'b000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE, TX_H0, TX_H1, TX_H2, TX_D, WAIT_CPL, DONE
    } state_t;

    state_t state, state_nxt;

    logic             op_wr;
    logic [9:0]       addr_q;
    logic [31:0]      wdata_q;
    logic [7:0]       tag_q;
    logic [7:0]       tag_cnt;
    logic [CNT_W-1:0] tmr;

    logic             accept;
    logic             op_wr_c;
    logic [9:0]       addr_c;
    logic [31:0]      wdata_c;
    logic [7:0]       tag_c;
    logic [31:0]      h0_c, h1_c, h2_c;

    logic             tx_valid_nxt, tx_sop_nxt, tx_eop_nxt;
    logic [31:0]      tx_data_nxt;
    logic [31:0]      rdata_nxt;
    logic             rvld_nxt;
    logic [2:0]       status_nxt;
    logic             terr_nxt;

    // Completion parser state
    logic             pkt_active;
    logic [IDX_W-1:0] idx_q, idx_c;
    logic             type_ok_q, type_ok_c;
    logic             cpld_q, cpld_c;
    logic [2:0]       status_q, status_c;
    logic             id_ok_q, id_ok_c;
    logic [31:0]      rdata_q, rdata_c;
    logic             rx_take;
    logic             cpl_hit;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cfg0w_addr[31:12], cfg0w_addr[1:0],
                                cfg0r_addr[31:12], cfg0r_addr[1:0]};

    // Request fields as seen by the beat being loaded next (bypass on accept)
    assign op_wr_c = accept ? cfg0w_en : op_wr;
    assign addr_c  = accept ? (cfg0w_en ? cfg0w_addr[11:2] : cfg0r_addr[11:2]) : addr_q;
    assign wdata_c = accept ? cfg0w_data : wdata_q;
    assign tag_c   = accept ? tag_cnt : tag_q;
    assign h0_c    = {(op_wr_c ? FT_WR : FT_RD), 8'h00, 6'b0, 10'd1};
    assign h1_c    = {REQ_ID, tag_c, 4'h0, 4'hF};
    assign h2_c    = {TARGET_BDF, 4'h0, addr_c, 2'b00};

    // RX beat decode; the current beat is folded in so a match can close on its eop
    always_comb begin
        rx_take   = rx_valid && (state == WAIT_CPL) && (rx_sop || pkt_active);
        idx_c     = rx_sop ? '0 : idx_q;
        type_ok_c = (idx_c == 3'd0) ? ((rx_data[31:24] == FT_CPLD) || (rx_data[31:24] == FT_CPL))
                                    : type_ok_q;
        cpld_c    = (idx_c == 3'd0) ? (rx_data[31:24] == FT_CPLD) : cpld_q;
        status_c  = (idx_c == 3'd1) ? rx_data[15:13] : status_q;
        rdata_c   = (idx_c == 3'd3) ? rx_data : rdata_q;
        id_ok_c   = 1'b0;
        if (idx_c == 3'd2) begin
            id_ok_c = (rx_data[31:16] == REQ_ID) && (rx_data[15:8] == tag_q);
        end else if (idx_c > 3'd2) begin
            id_ok_c = id_ok_q;
        end
        cpl_hit = rx_take && rx_eop && type_ok_c && id_ok_c;
    end

    always_ff @(posedge rc_core_clk) begin
        if (rst) begin
            pkt_active <= 1'b0;
            idx_q      <= '0;
            type_ok_q  <= 1'b0;
            cpld_q     <= 1'b0;
            status_q   <= '0;
            id_ok_q    <= 1'b0;
            rdata_q    <= '0;
        end else if (state != WAIT_CPL) begin
            pkt_active <= 1'b0;
        end else if (rx_take) begin
            pkt_active <= !rx_eop;
            idx_q      <= (idx_c == 3'd4) ? idx_c : idx_c + 3'd1;
            type_ok_q  <= type_ok_c;
            cpld_q     <= cpld_c;
            status_q   <= status_c;
            id_ok_q    <= id_ok_c;
            rdata_q    <= rdata_c;
        end
    end

    always_ff @(posedge rc_core_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        tx_valid_nxt = 1'b0;
        tx_sop_nxt   = 1'b0;
        tx_eop_nxt   = 1'b0;
        tx_data_nxt  = '0;
        rdata_nxt    = cfg0r_data;
        rvld_nxt     = 1'b0;
        status_nxt   = cpl_status;
        terr_nxt     = timeout_err;
        case (state)
            IDLE: begin
                if (op_start && (cfg0w_en || cfg0r_en)) begin
                    accept    = 1'b1;
                    state_nxt = TX_H0;
                end
            end
            TX_H0:    if (tx_ready) state_nxt = TX_H1;
            TX_H1:    if (tx_ready) state_nxt = TX_H2;
            TX_H2:    if (tx_ready) state_nxt = op_wr ? TX_D : WAIT_CPL;
            TX_D:     if (tx_ready) state_nxt = WAIT_CPL;
            WAIT_CPL: begin
                if (cpl_hit) begin
                    state_nxt  = DONE;
                    status_nxt = status_c;
                    if (!op_wr) begin
                        rdata_nxt = (cpld_c && (status_c == CPL_SC)) ? rdata_c : ALL_ONES;
                        rvld_nxt  = 1'b1;
                    end
                end else if (tmr == TMR_LAST) begin
                    state_nxt = DONE;
                    terr_nxt  = 1'b1;
                    if (!op_wr) begin
                        rdata_nxt = ALL_ONES;
                        rvld_nxt  = 1'b1;
                    end
                end
            end
            DONE:     if (!(op_wr ? cfg0w_en : cfg0r_en)) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (accept) begin
            terr_nxt = 1'b0;
        end
        // Beat presented in the next state; stalled beats are simply reloaded
        case (state_nxt)
            TX_H0: begin
                tx_valid_nxt = 1'b1;
                tx_sop_nxt   = 1'b1;
                tx_data_nxt  = h0_c;
            end
            TX_H1: begin
                tx_valid_nxt = 1'b1;
                tx_data_nxt  = h1_c;
            end
            TX_H2: begin
                tx_valid_nxt = 1'b1;
                tx_eop_nxt   = !op_wr_c;
                tx_data_nxt  = h2_c;
            end
            TX_D: begin
                tx_valid_nxt = 1'b1;
                tx_eop_nxt   = 1'b1;
                tx_data_nxt  = wdata_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge rc_core_clk) begin
        if (rst) begin
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tag_q   <= '0;
            tag_cnt <= '0;
        end else if (accept) begin
            op_wr   <= cfg0w_en;
            addr_q  <= addr_c;
            wdata_q <= cfg0w_data;
            tag_q   <= tag_cnt;
            tag_cnt <= tag_cnt + 8'd1;
        end
    end

    always_ff @(posedge rc_core_clk) begin
        if (rst || (state != WAIT_CPL)) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + CNT_W'(1);
        end
    end

    always_ff @(posedge rc_core_clk) begin
        if (rst) begin
            tx_valid       <= 1'b0;
            tx_sop         <= 1'b0;
            tx_eop         <= 1'b0;
            tx_data        <= '0;
            cfg0w_op_over  <= 1'b0;
            cfg0r_op_over  <= 1'b0;
            cfg0r_data     <= '0;
            cfg0r_data_vld <= 1'b0;
            cpl_status     <= '0;
            timeout_err    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            tx_valid       <= tx_valid_nxt;
            tx_sop         <= tx_sop_nxt;
            tx_eop         <= tx_eop_nxt;
            tx_data        <= tx_data_nxt;
            cfg0w_op_over  <= (state_nxt == DONE) && op_wr;
            cfg0r_op_over  <= (state_nxt == DONE) && !op_wr;
            cfg0r_data     <= rdata_nxt;
            cfg0r_data_vld <= rvld_nxt;
            cpl_status     <= status_nxt;
            timeout_err    <= terr_nxt;
            busy           <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_cfg0_req_engine.sv
// Randomized bench for cfg0_req_engine: expected TLPs, completion results,
// latencies and timeouts come from a transaction-level model kept here.
module tb_cfg0_req_engine;

    localparam logic [15:0] REQ_ID = 16'h0000;
    localparam logic [15:0] TGT    = 16'h0100;
    localparam int          TMO    = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg0w_en = 1'b0, cfg0r_en = 1'b0, op_start = 1'b0;
    logic [31:0] cfg0w_addr = '0, cfg0w_data = '0, cfg0r_addr = '0;
    logic        cfg0w_op_over, cfg0r_op_over, cfg0r_data_vld, timeout_err, busy;
    logic [31:0] cfg0r_data, tx_data;
    logic [2:0]  cpl_status;
    logic        tx_valid, tx_sop, tx_eop;
    logic        tx_ready = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0;

    cfg0_req_engine #(.REQ_ID(REQ_ID), .TARGET_BDF(TGT), .TIMEOUT_CYC(TMO)) dut (
        .rc_core_clk(clk), .rst(rst),
        .cfg0w_en(cfg0w_en), .cfg0r_en(cfg0r_en), .op_start(op_start),
        .cfg0w_addr(cfg0w_addr), .cfg0w_data(cfg0w_data), .cfg0r_addr(cfg0r_addr),
        .cfg0w_op_over(cfg0w_op_over), .cfg0r_op_over(cfg0r_op_over),
        .cfg0r_data(cfg0r_data), .cfg0r_data_vld(cfg0r_data_vld),
        .cpl_status(cpl_status), .timeout_err(timeout_err), .busy(busy),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [7:0]  exp_tag = '0;
    logic [31:0] exp_rdata = '0;
    logic [2:0]  exp_status = '0;
    logic        exp_terr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({pfx, "_tx_sop"}, 32'(tx_sop), 32'd0);
        check({pfx, "_tx_eop"}, 32'(tx_eop), 32'd0);
        check({pfx, "_tx_data"}, tx_data, 32'd0);
        check({pfx, "_w_over"}, 32'(cfg0w_op_over), 32'd0);
        check({pfx, "_r_over"}, 32'(cfg0r_op_over), 32'd0);
        check({pfx, "_rdata"}, cfg0r_data, 32'd0);
        check({pfx, "_rvld"}, 32'(cfg0r_data_vld), 32'd0);
        check({pfx, "_status"}, 32'(cpl_status), 32'd0);
        check({pfx, "_terr"}, 32'(timeout_err), 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic send_pkt(input logic [7:0] typ, input logic [2:0] st, input logic [15:0] rid,
                            input logic [7:0] tg, input logic [31:0] d3, input int n, input bit gaps);
        logic [31:0] dw [4];
        dw[0] = {typ, 8'h00, 6'b0, ((n == 4) ? 10'd1 : 10'd0)};
        dw[1] = {TGT, st, 1'b0, 12'd4};
        dw[2] = {rid, tg, 8'h00};
        dw[3] = d3;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_data = $urandom;
                step();
            end
            rx_valid = 1'b1; rx_sop = (i == 0); rx_eop = (i == n - 1); rx_data = dw[i];
            step();
        end
        rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    endtask

    // One request end to end: TX stream, optional junk, completion or timeout, release
    task automatic do_op(input bit is_wr, input bit both, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit fast, input int rdy_mode,
                         input bit tmo, input bit cpld, input logic [2:0] st,
                         input logic [31:0] rdat, input int njunk, input int jk, input bit late);
        logic [31:0] exp_tx [$];
        logic [31:0] pd;
        logic        ps, pe, pstall, ov;
        logic [7:0]  tag;
        int          start, w0, k, n, guard, kind, ngap, hold;
        tag = exp_tag;
        exp_tx = {};
        exp_tx.push_back({(is_wr ? 8'h44 : 8'h04), 8'h00, 6'b0, 10'd1});
        exp_tx.push_back({REQ_ID, tag, 4'h0, 4'hF});
        exp_tx.push_back({TGT, 4'h0, addr[11:2], 2'b00});
        if (is_wr) exp_tx.push_back(wdata);
        n = exp_tx.size();
        cfg0w_en = is_wr;
        cfg0r_en = !is_wr || both;
        cfg0w_addr = is_wr ? addr : $urandom;
        cfg0r_addr = is_wr ? $urandom : addr;
        cfg0w_data = is_wr ? wdata : $urandom;
        op_start = 1'b1;
        start = cyc;
        step();
        op_start = 1'b0;
        exp_tag = exp_tag + 8'd1;
        exp_terr = 1'b0;
        check("terr_clr", 32'(timeout_err), 32'd0);
        check("busy_tx", 32'(busy), 32'd1);
        k = 0; pstall = 1'b0; guard = 0; pd = '0; ps = 1'b0; pe = 1'b0;
        while (k < n && guard < 200) begin
            check("tx_valid", 32'(tx_valid), 32'd1);
            if (pstall) begin
                check("tx_hold_data", tx_data, pd);
                check("tx_hold_flags", 32'({tx_sop, tx_eop}), 32'({ps, pe}));
            end
            if (fast || rdy_mode == 0) tx_ready = 1'b1;
            else if (rdy_mode == 2)    tx_ready = guard[0];
            else                       tx_ready = ($urandom_range(0, 2) != 0);
            pd = tx_data; ps = tx_sop; pe = tx_eop;
            if (tx_ready) begin
                check("tx_dw", tx_data, exp_tx[k]);
                check("tx_sop", 32'(tx_sop), 32'(k == 0));
                check("tx_eop", 32'(tx_eop), 32'(k == n - 1));
                k++;
                pstall = 1'b0;
            end else begin
                pstall = 1'b1;
            end
            step();
            guard++;
        end
        check("tx_beats", k, n);
        tx_ready = $urandom_range(0, 1);
        w0 = cyc;
        check("tx_idle", 32'(tx_valid), 32'd0);
        for (int j = 0; j < njunk; j++) begin
            kind = (jk < 0) ? $urandom_range(0, 2) : jk;
            case (kind)
                0: send_pkt(8'h4A, 3'b000, REQ_ID, tag + 8'(1 + $urandom_range(0, 254)),
                            $urandom, 4, !fast);
                1: send_pkt(8'h4A, 3'b000, REQ_ID ^ 16'(1 + $urandom_range(0, 65534)), tag,
                            $urandom, 4, !fast);
                default: send_pkt(($urandom_range(0, 1) != 0) ? 8'h40 : 8'h4B, 3'b000,
                                  REQ_ID, tag, $urandom, 4, !fast);
            endcase
        end
        ngap = fast ? 0 : $urandom_range(0, 3);
        for (int g = 0; g < ngap; g++) begin
            op_start = ($urandom_range(0, 2) == 0);
            step();
            op_start = 1'b0;
        end
        if (!tmo) begin
            send_pkt(cpld ? 8'h4A : 8'h0A, st, REQ_ID, tag, rdat, cpld ? 4 : 3, !fast);
            exp_status = st;
            if (!is_wr) exp_rdata = (cpld && st == 3'b000) ? rdat : 32'hFFFF_FFFF;
        end else begin
            ov = 1'b0;
            while (!ov && (cyc - w0) < TMO + 20) begin
                step();
                ov = is_wr ? cfg0w_op_over : cfg0r_op_over;
            end
            check("tmo_cycles", cyc - w0, TMO);
            exp_terr = 1'b1;
            if (!is_wr) exp_rdata = 32'hFFFF_FFFF;
        end
        if (fast) check("latency", cyc - start, 8);
        check("op_over", 32'(is_wr ? cfg0w_op_over : cfg0r_op_over), 32'd1);
        check("op_over_other", 32'(is_wr ? cfg0r_op_over : cfg0w_op_over), 32'd0);
        check("rd_vld", 32'(cfg0r_data_vld), 32'(!is_wr));
        check("rd_data", cfg0r_data, exp_rdata);
        check("status", 32'(cpl_status), 32'(exp_status));
        check("terr", 32'(timeout_err), 32'(exp_terr));
        step();
        check("vld_pulse", 32'(cfg0r_data_vld), 32'd0);
        check("op_over_hold", 32'(is_wr ? cfg0w_op_over : cfg0r_op_over), 32'd1);
        if (late) begin
            send_pkt(8'h4A, 3'(1 + $urandom_range(0, 1)), REQ_ID, tag, $urandom, 4, 1'b0);
            check("late_status", 32'(cpl_status), 32'(exp_status));
            check("late_data", cfg0r_data, exp_rdata);
            check("late_over", 32'(is_wr ? cfg0w_op_over : cfg0r_op_over), 32'd1);
        end
        hold = fast ? 0 : $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) step();
        cfg0w_en = 1'b0;
        cfg0r_en = 1'b0;
        step();
        check("release_w", 32'(cfg0w_op_over), 32'd0);
        check("release_r", 32'(cfg0r_op_over), 32'd0);
        check("release_busy", 32'(busy), 32'd0);
    endtask

    task automatic idle_start();
        cfg0w_en = 1'b0; cfg0r_en = 1'b0; op_start = 1'b1;
        step();
        op_start = 1'b0;
        check("noen_busy", 32'(busy), 32'd0);
        check("noen_txv", 32'(tx_valid), 32'd0);
    endtask

    task automatic reset_mid_wait();
        logic [7:0] tag;
        tag = exp_tag;
        cfg0r_en = 1'b1; cfg0w_en = 1'b0; cfg0r_addr = $urandom; tx_ready = 1'b1;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_txv", 32'(tx_valid), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("midrst");
        exp_tag = '0; exp_rdata = '0; exp_status = '0; exp_terr = 1'b0;
        send_pkt(8'h4A, 3'b000, REQ_ID, tag, $urandom, 4, 1'b0);
        step();
        check("stale_over", 32'(cfg0r_op_over), 32'd0);
        check("stale_busy", 32'(busy), 32'd0);
        check("stale_data", cfg0r_data, 32'd0);
        cfg0r_en = 1'b0;
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] st;
        bit         w;
        rst = 1'b1;
        repeat (3) step();
        check_reset("reset");
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        do_op(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 0, 1'b0, 1'b1, 3'b000, 32'h1234_10EE, 0, -1, 1'b0);
        do_op(1'b1, 1'b0, 32'h0000_0004, 32'h0011_0007, 1'b0, 2, 1'b0, 1'b0, 3'b000, 32'h0, 0, -1, 1'b0);
        do_op(1'b0, 1'b0, 32'h0000_0A08, 32'h0, 1'b0, 1, 1'b0, 1'b0, 3'b001, 32'h0, 1, 0, 1'b0);
        do_op(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1, 1'b1, 1'b1, 3'b000, 32'h0, 0, -1, 1'b1);
        do_op(1'b1, 1'b1, 32'h0000_0FFC, $urandom, 1'b1, 0, 1'b0, 1'b0, 3'b000, 32'h0, 0, -1, 1'b0);

        for (int i = 0; i < 257; i++) begin
            do_op(1'b0, 1'b0, $urandom, 32'h0, 1'b1, 0, 1'b0, 1'b1, 3'b000, $urandom, 0, -1, 1'b0);
        end

        reset_mid_wait();
        idle_start();

        for (int i = 0; i < 200; i++) begin
            w = ($urandom_range(0, 1) != 0);
            case ($urandom_range(0, 4))
                0, 1:    st = 3'b000;
                2:       st = 3'b001;
                3:       st = 3'b010;
                default: st = 3'b100;
            endcase
            if ($urandom_range(0, 7) == 0) idle_start();
            do_op(w, w && ($urandom_range(0, 1) != 0), $urandom, $urandom, 1'b0, 1,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 1) != 0), st, $urandom,
                  $urandom_range(0, 2), -1, ($urandom_range(0, 1) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
